cpu6_alu_arb: RTL and testbench
===============================

// Module: cpu6_alu_arb
// PURPOSE
//  Two-requester arbiter and sequencer for the shared cpu6_alu instance. Requester 0 is the EX stage and requester 1 is the address/branch helper.
//  Grants one valid/ready request at a time (round-robin), latches its operands, and drives the ALU for one evaluation cycle.
//  Registers y/zero and returns them on the winner's response channel. Sits between the issue logic and the single ALU.
// PARAMETERS
//  XLEN          `CPU6_XLEN              operand/result width
//  CTRL_W        `CPU6_ALUCONTROL_SIZE   ALU control field width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high reset
//  req0_valid   in   1       requester 0 has an operation
//  req0_ready   out  1       requester 0 operation accepted this cycle
//  req0_a       in   XLEN    requester 0 operand a
//  req0_b       in   XLEN    requester 0 operand b
//  req0_ctrl    in   CTRL_W  requester 0 ALU control
//  resp0_valid  out  1       result for requester 0 available
//  resp0_ready  in   1       requester 0 takes result
//  resp0_y      out  XLEN    result value
//  resp0_zero   out  1       result zero flag
//  req1_*/resp1_*            identical set for requester 1
//  alu_a        out  XLEN    to ALU a (registered)
//  alu_b        out  XLEN    to ALU b (registered)
//  alu_control  out  CTRL_W  to ALU control (registered)
//  alu_y        in   XLEN    from ALU y
//  alu_zero     in   1       from ALU zero
// BEHAVIOUR
//  - Clock/reset: one clock clk; reset is asynchronous and active-high.
//  - Reset values: state=IDLE, prio=0, owner=0; alu_a/alu_b/alu_control=0; result y=0, zero=0; all *_ready/*_valid=0.
//  - FSM states:
//    IDLE: arbitrate. Leave only on accept (reqN_valid & reqN_ready) -> EXEC.
//    EXEC: ALU sees the latched operands; capture alu_y/alu_zero at end of cycle -> RESP.
//    RESP: respN_valid=1 for owner only. On respN_ready -> IDLE; else hold y/zero stable.
//  - Grant:
//    - reqN_ready is combinational and high only in IDLE for the granted N; never both high.
//    - Only one valid requester: grant it.
//    - Both valid: grant prio; after accept, prio <= ~owner.
//    - prio changes only on accept.
//  - Accept latches: on accept, owner<=N, alu_a<=reqN_a, alu_b<=reqN_b, alu_control<=reqN_ctrl.
//  - ALU outputs: alu_* hold their value until the next accept.
//  - Latency: accept at cycle T; respN_valid at T+2. Best-case throughput 1 op per 3 cycles (RESP->IDLE->accept).
//  - Response outputs: resp0_y and resp1_y both carry the result register. Only the owner's valid is asserted.
//  - Width/encoding: no width conversion. ctrl is passed unmodified. Unsupported encodings return whatever the ALU gives (y=0, zero=0 for cpu6_alu).
//  - Requester rules: may deassert valid or change operands while not accepted, with no effect. Block never drops an accepted op except on reset.
//  - Response stall: a held response back-pressures both requesters; no new grant until RESP exits.
//  - Reset mid-op: any state -> IDLE immediately. In-flight op is discarded with no response; prio returns to 0.
// TESTING
//  - Single op: req0 ADD a=5 b=3 at T -> req0_ready@T, resp0_valid@T+2, y=8, zero=0. req1 never ready/valid.
//  - Zero flag: req1 SUB a=7 b=7 -> resp1 y=0, zero=1. AND 0xF0&0x0F -> y=0, zero=0.
//  - Contention: both valid continuously -> grants alternate 0,1,0,1. Each resp on the correct port; results match per-port operands.
//  - Back-pressure: resp0_ready low 5 cycles -> resp0_valid and y held; no req*_ready asserted. Release -> IDLE next cycle, then grant.
//  - Reset mid-op: assert reset in EXEC -> all outputs 0 asynchronously; no resp after release. Next grant goes to req0 when both valid.
//  - Unsupported ctrl: req0 ctrl=unused code, a=1 b=1 -> resp0 y=0, zero=0, latency still 2.

Source files
------------

// File: rtl/cpu6_alu_arb.sv
// Round-robin arbiter sharing one ALU between the EX stage (req 0) and the address/branch helper (req 1).
// Accept-to-response latency is 2 cycles; a stalled response blocks every new grant until it is taken.

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_ALUCONTROL_SIZE
`define CPU6_ALUCONTROL_SIZE 4
`endif

module cpu6_alu_arb #(
  parameter int XLEN   = `CPU6_XLEN,
  parameter int CTRL_W = `CPU6_ALUCONTROL_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [XLEN-1:0]   resp0_y,
  output logic              resp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [XLEN-1:0]   resp1_y,
  output logic              resp1_zero,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]   alu_y,
  input  logic              alu_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0]   y_q, y_d;
  logic              zero_q, zero_d;

  logic idle;
  logic grant0;
  logic grant1;
  logic resp_take;

  always_comb begin
    // Ready is masked by reset so nothing looks accepted while the block is held in reset.
    idle        = (state_q == S_IDLE) && !reset;
    grant0      = req0_valid && (!req1_valid || !prio_q);
    grant1      = req1_valid && (!req0_valid || prio_q);
    req0_ready  = idle && grant0;
    req1_ready  = idle && grant1;
    resp0_valid = (state_q == S_RESP) && !owner_q;
    resp1_valid = (state_q == S_RESP) && owner_q;
    resp_take   = owner_q ? resp1_ready : resp0_ready;

    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    y_d        = y_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d    = S_EXEC;
          owner_d    = req1_ready;
          prio_d     = !req1_ready;
          alu_a_d    = req1_ready ? req1_a    : req0_a;
          alu_b_d    = req1_ready ? req1_b    : req0_b;
          alu_ctrl_d = req1_ready ? req1_ctrl : req0_ctrl;
        end
      end
      S_EXEC: begin
        y_d     = alu_y;
        zero_d  = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_take) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      y_q        <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign resp0_y     = y_q;
  assign resp1_y     = y_q;
  assign resp0_zero  = zero_q;
  assign resp1_zero  = zero_q;

endmodule

// File: tb/tb_cpu6_alu_arb.sv
// Scoreboard bench for cpu6_alu_arb with a behavioural ALU stand-in and a spec-level arbitration model.
// A forked monitor owns the model; the main thread drives directed and random traffic.

module tb_cpu6_alu_arb;

  localparam int XLEN = 32;
  localparam int CW   = 4;
  localparam logic [CW-1:0] OP_AND = 4'h0;
  localparam logic [CW-1:0] OP_OR  = 4'h1;
  localparam logic [CW-1:0] OP_ADD = 4'h2;
  localparam logic [CW-1:0] OP_SUB = 4'h6;
  localparam logic [CW-1:0] OP_SLT = 4'h7;
  localparam logic [CW-1:0] OP_BAD = 4'hF;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic            req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic            req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b, resp0_y, resp1_y;
  logic [CW-1:0]   req0_ctrl, req1_ctrl;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic [CW-1:0]   alu_control;
  logic            alu_zero;

  logic [1:0]      rv;
  logic [1:0]      rr;
  logic [XLEN-1:0] ra [2];
  logic [XLEN-1:0] rb [2];
  logic [CW-1:0]   rc [2];

  assign req0_valid  = rv[0];
  assign req1_valid  = rv[1];
  assign req0_a      = ra[0];
  assign req1_a      = ra[1];
  assign req0_b      = rb[0];
  assign req1_b      = rb[1];
  assign req0_ctrl   = rc[0];
  assign req1_ctrl   = rc[1];
  assign resp0_ready = rr[0];
  assign resp1_ready = rr[1];

  cpu6_alu_arb #(.XLEN(XLEN), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_y(resp0_y), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_y(resp1_y), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_y(alu_y), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // ALU behaviour: zero flag only meaningful for SUB (branch compare); unknown codes give 0/0.
  function automatic logic [XLEN:0] alu_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [CW-1:0] c);
    logic [XLEN-1:0] y;
    logic            z;
    case (c)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = ($signed(a) < $signed(b)) ? 1 : 0;
      default: y = '0;
    endcase
    z = (c == OP_SUB) && (y == 0);
    return {z, y};
  endfunction

  always_comb {alu_zero, alu_y} = alu_fn(alu_a, alu_b, alu_control);

  typedef struct {
    int              port;
    logic [XLEN-1:0] y;
    logic            z;
  } exp_t;

  exp_t            exp_q[$];
  int              grant_log[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              acc_cyc = 0;
  bit              busy = 1'b0;
  int              rr_prio = 0;
  int              acc_cnt[2] = '{0, 0};
  int              seen[2] = '{0, 0};
  bit              refill[2] = '{1'b0, 1'b0};
  logic [1:0]      prev_v = 2'b00;
  logic [XLEN-1:0] last_y = '0;
  logic            last_z = 1'b0;
  int              last_p = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [1:0]      qv, qr, sv, acc;
    logic [1:0]      exp_grant;
    logic [XLEN:0]   r;
    exp_t            e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
        busy    = 1'b0;
        rr_prio = 0;
        prev_v  = 2'b00;
      end else begin
        qv = rv;
        qr = {req1_ready, req0_ready};
        sv = {resp1_valid, resp0_valid};
        if (!busy && qv != 2'b00) begin
          exp_grant = (qv == 2'b11) ? ((rr_prio == 1) ? 2'b10 : 2'b01) : qv;
          chk("grant", qr, exp_grant);
        end else begin
          chk("no_grant", qr, 2'b00);
        end
        acc = qv & qr;
        for (int p = 0; p < 2; p++) begin
          if (acc[p]) begin
            r      = alu_fn(ra[p], rb[p], rc[p]);
            e.port = p;
            e.y    = r[XLEN-1:0];
            e.z    = r[XLEN];
            exp_q.push_back(e);
            acc_cyc = cyc;
            busy    = 1'b1;
            rr_prio = 1 - p;
            acc_cnt[p]++;
            grant_log.push_back(p);
          end
        end
        if (sv != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", sv, 2'b00);
          end else begin
            e = exp_q[0];
            chk("resp_port", sv, (e.port == 1) ? 2'b10 : 2'b01);
            chk("resp0_y", resp0_y, e.y);
            chk("resp1_y", resp1_y, e.y);
            chk("resp_zero", (e.port == 1) ? resp1_zero : resp0_zero, e.z);
            if (prev_v == 2'b00) chk("latency", cyc - acc_cyc, 2);
            if (rr[e.port]) begin
              void'(exp_q.pop_front());
              busy   = 1'b0;
              last_y = e.port == 1 ? resp1_y : resp0_y;
              last_z = e.port == 1 ? resp1_zero : resp0_zero;
              last_p = e.port;
            end
          end
        end
        prev_v = sv;
      end
    end
  endtask

  task automatic new_op(input int p);
    case ($urandom_range(0, 5))
      0:       rc[p] = OP_AND;
      1:       rc[p] = OP_OR;
      2:       rc[p] = OP_ADD;
      3:       rc[p] = OP_SUB;
      4:       rc[p] = OP_SLT;
      default: rc[p] = OP_BAD;
    endcase
    ra[p] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) rb[p] = ra[p];
    else rb[p] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (acc_cnt[p] != seen[p]) begin
        seen[p] = acc_cnt[p];
        if (refill[p]) new_op(p);
        else rv[p] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int p, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [CW-1:0] c);
    rv[p] = 1'b1;
    ra[p] = a;
    rb[p] = b;
    rc[p] = c;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (busy || exp_q.size() != 0 || rv != 2'b00); i++) step();
    chk("drain_timeout", (busy || exp_q.size() != 0 || rv != 2'b00), 0);
  endtask

  initial begin
    rv = 2'b11;
    rr = 2'b11;
    for (int p = 0; p < 2; p++) begin
      ra[p] = 32'h11;
      rb[p] = 32'h22;
      rc[p] = OP_ADD;
    end
    fork
      monitor();
    join_none

    #1;
    chk("rst_req_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_resp_valid", {resp1_valid, resp0_valid}, 2'b00);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_control, 0);
    chk("rst_y", {resp1_y, resp0_y}, 0);
    chk("rst_zero", {resp1_zero, resp0_zero}, 2'b00);
    rv = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single operation on requester 0.
    step();
    issue(0, 5, 3, OP_ADD);
    @(negedge clk);
    chk("single_ready", {req1_ready, req0_ready}, 2'b01);
    drain();
    chk("single_port", last_p, 0);
    chk("single_y", last_y, 8);
    chk("single_zero", last_z, 0);

    issue(1, 7, 7, OP_SUB);
    drain();
    chk("sub_port", last_p, 1);
    chk("sub_y", last_y, 0);
    chk("sub_zero", last_z, 1);

    issue(0, 32'hF0, 32'h0F, OP_AND);
    drain();
    chk("and_y", last_y, 0);
    chk("and_zero", last_z, 0);

    issue(0, 1, 1, OP_BAD);
    drain();
    chk("bad_y", last_y, 0);
    chk("bad_zero", last_z, 0);

    issue(1, 100, 58, OP_SUB);
    drain();
    chk("sub2_y", last_y, 42);

    // Response back-pressure holds the result and blocks new grants.
    rr[0] = 1'b0;
    issue(0, 10, 20, OP_ADD);
    step();
    step();
    issue(1, 3, 4, OP_ADD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", resp0_valid, 1);
      chk("bp_y", resp0_y, 30);
      chk("bp_noready", {req1_ready, req0_ready}, 2'b00);
      step();
    end
    rr[0] = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_regrant", {req1_ready, req0_ready}, 2'b10);
    drain();
    chk("bp_last_y", last_y, 7);

    // Reset while the ALU is evaluating.
    issue(0, 9, 9, OP_SUB);
    @(negedge clk);
    @(posedge clk);
    #1;
    rv = 2'b11;
    reset = 1'b1;
    #1;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_ctrl", alu_control, 0);
    chk("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("mid_rst_valid", {resp1_valid, resp0_valid}, 2'b00);
    chk("mid_rst_y", resp0_y, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rv = 2'b00;
    seen[0] = acc_cnt[0];
    seen[1] = acc_cnt[1];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {resp1_valid, resp0_valid}, 2'b00);
    end

    // Continuous contention alternates grants starting with requester 0.
    @(posedge clk);
    #1;
    grant_log.delete();
    refill[0] = 1'b1;
    refill[1] = 1'b1;
    new_op(0);
    new_op(1);
    rv = 2'b11;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) step();
    chk("rr_count", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", grant_log[i], i % 2);
    end
    refill[0] = 1'b0;
    refill[1] = 1'b0;
    drain();

    // Random traffic with random response stalls.
    for (int it = 0; it < 600; it++) begin
      step();
      rr = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        if (!rv[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            new_op(p);
            rv[p] = 1'b1;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 1) new_op(p);
          else rv[p] = 1'b0;
        end
      end
    end
    rr = 2'b11;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
